// File: rtl/max7219_cmd_scheduler_if.sv
// Command word channel between the scheduler and the 16-bit SPI serializer.
interface max7219_cmd_scheduler_if;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (output cmd_data, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/max7219_cmd_scheduler.sv
// MAX7219 command scheduler: power-up init sequence, intensity updates and
// 8-row frame refreshes, arbitrated in IDLE and streamed over valid/ready.
module max7219_cmd_scheduler #(
    parameter logic [3:0]  INIT_INTENSITY = 4'h8,
    parameter int unsigned REINIT_FRAMES  = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [63:0]                     pixels,
    input  logic                            frame_valid,
    input  logic                            int_req,
    input  logic [3:0]                      int_level,
    max7219_cmd_scheduler_if.master         cmd,
    output logic                            busy,
    output logic                            init_done,
    output logic                            frame_done
);

    localparam int unsigned CNT_W = (REINIT_FRAMES > 0) ? $clog2(REINIT_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] REINIT_MAX = CNT_W'(REINIT_FRAMES);

    typedef enum logic [1:0] {IDLE, INIT, INTENS, ROWS} state_t;

    state_t           state;
    logic [2:0]       step;
    logic [3:0]       intensity;
    logic             int_pend;
    logic             frame_pend;
    logic [63:0]      pending_frame;
    logic [63:0]      active_frame;
    logic [CNT_W-1:0] frame_cnt;
    logic             xfer;
    logic             reinit_due;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] lvl);
        case (idx)
            3'd0:    init_word = 16'h0C00;
            3'd1:    init_word = 16'h0F00;
            3'd2:    init_word = 16'h0900;
            3'd3:    init_word = 16'h0B07;
            3'd4:    init_word = {8'h0A, 4'h0, lvl};
            default: init_word = 16'h0C01;
        endcase
    endfunction

    // Row idx (0..7) goes to digit register idx+1; row 0 is the top byte.
    function automatic logic [15:0] row_word(input logic [63:0] frame, input logic [2:0] idx);
        logic [63:0] sh;
        sh = frame << {idx, 3'b000};
        row_word = {{5'd0, idx} + 8'd1, sh[63:56]};
    endfunction

    // Transfer strobe and re-init condition used by the FSM.
    always_comb begin
        xfer       = cmd.cmd_valid & cmd.cmd_ready;
        reinit_due = (REINIT_FRAMES != 0) && (frame_cnt == REINIT_MAX);
    end

    // Sequencer FSM with registered outputs; request capture shares the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            step          <= '0;
            intensity     <= INIT_INTENSITY;
            int_pend      <= 1'b0;
            frame_pend    <= 1'b0;
            pending_frame <= '0;
            active_frame  <= '0;
            frame_cnt     <= '0;
            cmd.cmd_data  <= '0;
            cmd.cmd_valid <= 1'b0;
            busy          <= 1'b0;
            init_done     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!init_done || reinit_due) begin
                        state         <= INIT;
                        step          <= '0;
                        cmd.cmd_data  <= init_word(3'd0, intensity);
                        cmd.cmd_valid <= 1'b1;
                        busy          <= 1'b1;
                    end else if (int_pend) begin
                        state         <= INTENS;
                        int_pend      <= 1'b0;
                        cmd.cmd_data  <= {8'h0A, 4'h0, intensity};
                        cmd.cmd_valid <= 1'b1;
                        busy          <= 1'b1;
                    end else if (frame_pend) begin
                        state         <= ROWS;
                        step          <= '0;
                        frame_pend    <= 1'b0;
                        active_frame  <= pending_frame;
                        cmd.cmd_data  <= row_word(pending_frame, 3'd0);
                        cmd.cmd_valid <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                INIT: begin
                    if (xfer) begin
                        if (step == 3'd5) begin
                            state         <= IDLE;
                            cmd.cmd_valid <= 1'b0;
                            busy          <= 1'b0;
                            init_done     <= 1'b1;
                            frame_cnt     <= '0;
                        end else begin
                            step         <= step + 3'd1;
                            cmd.cmd_data <= init_word(step + 3'd1, intensity);
                        end
                    end
                end
                INTENS: begin
                    if (xfer) begin
                        state         <= IDLE;
                        cmd.cmd_valid <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                ROWS: begin
                    if (xfer) begin
                        if (step == 3'd7) begin
                            state         <= IDLE;
                            cmd.cmd_valid <= 1'b0;
                            busy          <= 1'b0;
                            frame_done    <= 1'b1;
                            if (frame_cnt != REINIT_MAX) begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end else begin
                            step         <= step + 3'd1;
                            cmd.cmd_data <= row_word(active_frame, step + 3'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed after the FSM so a new request in the same cycle the
            // pending one is consumed re-arms the flag instead of being lost.
            if (frame_valid) begin
                pending_frame <= pixels;
                frame_pend    <= 1'b1;
            end
            if (int_req) begin
                intensity <= int_level;
                int_pend  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_max7219_cmd_scheduler.sv
// Self-checking bench for max7219_cmd_scheduler: directed scenarios plus a
// randomized phase, all checked cycle by cycle against a word-queue model.
module tb_max7219_cmd_scheduler;

    localparam int unsigned REINIT = 2;
    localparam logic [15:0] PH = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pixels;
    logic        frame_valid;
    logic        int_req;
    logic [3:0]  int_level;
    logic        busy;
    logic        init_done;
    logic        frame_done;

    max7219_cmd_scheduler_if bus();

    max7219_cmd_scheduler #(
        .INIT_INTENSITY (4'h8),
        .REINIT_FRAMES  (REINIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixels      (pixels),
        .frame_valid (frame_valid),
        .int_req     (int_req),
        .int_level   (int_level),
        .cmd         (bus),
        .busy        (busy),
        .init_done   (init_done),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each command sequence is a queue of words; the front
    // is the word on the bus. The intensity word of init is resolved only when
    // it reaches the front, since late int_req pulses may still change it.
    logic [15:0] m_q[$];
    logic [15:0] m_data;
    bit          m_busy, m_init_done, m_fd, m_ip, m_fp;
    int          m_kind;
    int unsigned m_cnt;
    logic [3:0]  m_int;
    logic [63:0] m_pf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_data = '0; m_busy = 0; m_init_done = 0; m_fd = 0;
            m_ip = 0; m_fp = 0; m_kind = 0; m_cnt = 0; m_int = 4'h8; m_pf = '0;
        end else begin
            m_fd = 0;
            if (m_busy) begin
                if (bus.cmd_ready === 1'b1) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_busy = 0;
                        if (m_kind == 0) begin
                            m_init_done = 1;
                            m_cnt = 0;
                        end else if (m_kind == 2) begin
                            m_fd = 1;
                            if (m_cnt < REINIT) m_cnt++;
                        end
                    end else begin
                        if (m_q[0] == PH) m_q[0] = {8'h0A, 4'h0, m_int};
                        m_data = m_q[0];
                    end
                end
            end else begin
                if (!m_init_done || m_cnt == REINIT) begin
                    m_q = '{16'h0C00, 16'h0F00, 16'h0900, 16'h0B07, PH, 16'h0C01};
                    m_kind = 0;
                end else if (m_ip) begin
                    m_q = '{{8'h0A, 4'h0, m_int}};
                    m_ip = 0;
                    m_kind = 1;
                end else if (m_fp) begin
                    logic [63:0] f;
                    f = m_pf;
                    for (int k = 1; k <= 8; k++) begin
                        m_q.push_back({8'(k), f[63:56]});
                        f = f << 8;
                    end
                    m_fp = 0;
                    m_kind = 2;
                end
                if (m_q.size() != 0) begin
                    m_busy = 1;
                    m_data = m_q[0];
                end
            end
            if (frame_valid) begin m_pf = pixels; m_fp = 1; end
            if (int_req) begin m_int = int_level; m_ip = 1; end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cmd_valid",  64'(bus.cmd_valid), 64'(m_q.size() != 0));
        check("cmd_data",   64'(bus.cmd_data),  64'(m_data));
        check("busy",       64'(busy),          64'(m_busy));
        check("init_done",  64'(init_done),     64'(m_init_done));
        check("frame_done", 64'(frame_done),    64'(m_fd));
    end

    // Log of words actually accepted by the serializer.
    logic [15:0] sent[$];
    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst && bus.cmd_valid && bus.cmd_ready) sent.push_back(bus.cmd_data);
    end

    task automatic push_init(input logic [3:0] lvl);
        exp_q.push_back(16'h0C00); exp_q.push_back(16'h0F00); exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0B07); exp_q.push_back({8'h0A, 4'h0, lvl}); exp_q.push_back(16'h0C01);
    endtask

    task automatic push_rows(input logic [63:0] fr);
        for (int k = 0; k < 8; k++) exp_q.push_back({8'(k + 1), fr[63 - 8 * k -: 8]});
    endtask

    task automatic compare_sent(input string tag);
        check({tag, "_len"}, 64'(sent.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
            check({tag, "_word"}, 64'(sent[i]), 64'(exp_q[i]));
        sent.delete();
        exp_q.delete();
    endtask

    task automatic idle_wait();
        int unsigned quiet = 0;
        for (int unsigned i = 0; i < 1000 && quiet < 4; i++) begin
            @(posedge clk); #1;
            quiet = busy ? 0 : quiet + 1;
        end
        check("idle_timeout", 64'(quiet >= 4), 64'd1);
    endtask

    task automatic pulse_frame(input logic [63:0] p);
        pixels = p; frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] fa, fb, fc, fd;
        bit reached;
        rst = 1'b1; pixels = '0; frame_valid = 0; int_req = 0; int_level = '0;
        bus.cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.cmd_valid), 64'd0);
        check("rst_data",  64'(bus.cmd_data),  64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_init",  64'(init_done), 64'd0);

        // Power-up init
        rst = 1'b0;
        idle_wait();
        push_init(4'h8);
        compare_sent("init");
        check("init_done_hi", 64'(init_done), 64'd1);

        // Single frame, 2-cycle latency from pulse to cmd_valid
        pulse_frame(64'h18181818FFFF1818);
        check("lat_1cyc", 64'(bus.cmd_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_2cyc", 64'(bus.cmd_valid), 64'd1);
        check("first_row", 64'(bus.cmd_data), 64'h0118);
        idle_wait();
        exp_q = '{16'h0118, 16'h0218, 16'h0318, 16'h0418, 16'h05FF, 16'h06FF, 16'h0718, 16'h0818};
        compare_sent("frame1");

        // Same frame with stalls; second frame reaches the re-init threshold
        for (int i = 0; i < 40; i++) begin
            bus.cmd_ready = (i % 4 == 0 || i % 4 == 3);
            pixels = 64'h18181818FFFF1818;
            frame_valid = (i == 0);
            @(posedge clk); #1;
        end
        frame_valid = 1'b0;
        bus.cmd_ready = 1'b1;
        idle_wait();
        push_rows(64'h18181818FFFF1818);
        push_init(4'h8);
        compare_sent("stall_reinit");
        check("init_done_kept", 64'(init_done), 64'd1);

        // Requests during ROWS: B supersedes A, intensity goes first
        fc = {$urandom, $urandom}; fa = {$urandom, $urandom}; fb = ~fa;
        pulse_frame(fc);
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(posedge clk); #1;
            reached = (sent.size() >= 2);
        end
        check("rows_started", 64'(reached), 64'd1);
        pulse_frame(fa);
        pulse_frame(fb);
        int_level = 4'h3; int_req = 1'b1;
        @(posedge clk); #1;
        int_req = 1'b0;
        idle_wait();
        push_rows(fc);
        exp_q.push_back(16'h0A03);
        push_rows(fb);
        push_init(4'h3);
        compare_sent("supersede");

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 400; i++) begin
            pixels      = {$urandom, $urandom};
            frame_valid = ($urandom_range(7) == 0);
            int_req     = ($urandom_range(15) == 0);
            int_level   = 4'($urandom);
            bus.cmd_ready = ($urandom_range(3) != 0);
            @(posedge clk); #1;
        end
        frame_valid = 0; int_req = 0; bus.cmd_ready = 1'b1;
        idle_wait();
        sent.delete();

        // Reset in the middle of a frame
        fd = {$urandom, $urandom};
        pulse_frame(fd);
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (sent.size() >= 4) reached = 1;
            else begin @(posedge clk); #1; end
        end
        check("row4_reached", 64'(reached), 64'd1);
        rst = 1'b1;
        #1;
        check("async_valid", 64'(bus.cmd_valid), 64'd0);
        check("async_busy",  64'(busy), 64'd0);
        check("async_init",  64'(init_done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        sent.delete();
        rst = 1'b0;
        idle_wait();
        repeat (10) @(posedge clk);
        #1;
        push_init(4'h8);
        compare_sent("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
